// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select generation for NSRC operands over NSTG producer stages,
// plus load-use hazard detection with a multi-cycle stall FSM and stall statistics.
module fwd_hazard_unit #(
  parameter int NSRC     = 2,
  parameter int NSTG     = 2,
  parameter int RW       = 5,
  parameter int CW       = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic               flush,
  input  logic [NSRC*RW-1:0] rs_i,
  input  logic [NSRC-1:0]    rs_use_i,
  input  logic [NSTG*RW-1:0] wr_rn_i,
  input  logic [NSTG-1:0]    we_i,
  input  logic [NSTG-1:0]    ld_i,
  input  logic               cnt_clr_i,
  output logic [NSRC*CW-1:0] cmp_fw_o,
  output logic [NSRC*CW-1:0] alu_fw_o,
  output logic               stall_o,
  output logic               bubble_o,
  output logic [15:0]        stall_cnt_o
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [RW-1:0] HOLD_INIT = RW'(LOAD_LAT - 1);

  state_t            state, state_nxt;
  logic [RW-1:0]     cnt, cnt_nxt;
  logic [NSRC*RW-1:0] ex_rn;
  logic [NSRC-1:0]   ex_use;
  logic              haz_hit, haz;
  logic              unused_ld;

  // Only stage 0 can still be waiting on load data; older stages are forwardable.
  assign unused_ld = ^ld_i;

  // Scan oldest to youngest so the youngest matching stage overrides.
  function automatic logic [CW-1:0] fw_sel(input logic [RW-1:0]      rn,
                                           input logic [NSTG*RW-1:0] wr_rn,
                                           input logic [NSTG-1:0]    we);
    fw_sel = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (we[k] && (wr_rn[k*RW +: RW] == rn) && (rn != '0))
        fw_sel = CW'(k + 1);
    end
  endfunction

  always_comb begin
    for (int j = 0; j < NSRC; j++) begin
      cmp_fw_o[j*CW +: CW] = fw_sel(rs_i[j*RW +: RW], wr_rn_i, we_i);
      alu_fw_o[j*CW +: CW] = ex_use[j] ? fw_sel(ex_rn[j*RW +: RW], wr_rn_i, we_i) : '0;
    end
  end

  always_comb begin
    haz_hit = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      if (rs_use_i[j] && ld_i[0] && we_i[0] &&
          (wr_rn_i[RW-1:0] == rs_i[j*RW +: RW]) && (rs_i[j*RW +: RW] != '0))
        haz_hit = 1'b1;
    end
    haz = (state == IDLE) && haz_hit;
  end

  assign stall_o  = haz | (state == HOLD);
  assign bubble_o = stall_o & ~pause;

  // The detection cycle counts as the first stall cycle, so HOLD lasts LOAD_LAT-1 cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (!pause) begin
      case (state)
        IDLE: begin
          if (haz && (LOAD_LAT > 1)) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_INIT;
          end
        end
        HOLD: begin
          if (cnt <= RW'(1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - RW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // EX-stage copy of the decode operands; a bubble loads a NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rn  <= '0;
      ex_use <= '0;
    end else if (flush) begin
      ex_rn  <= '0;
      ex_use <= '0;
    end else if (!pause) begin
      if (bubble_o) begin
        ex_rn  <= '0;
        ex_use <= '0;
      end else begin
        ex_rn  <= rs_i;
        ex_use <= rs_use_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (cnt_clr_i)
      stall_cnt_o <= '0;
    else if (stall_o && !pause && (stall_cnt_o != 16'hFFFF))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit (NSRC=2, NSTG=2, RW=5, CW=3, LOAD_LAT=3).
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic        pause;
  logic        flush;
  logic [9:0]  rs_i;
  logic [1:0]  rs_use_i;
  logic [9:0]  wr_rn_i;
  logic [1:0]  we_i;
  logic [1:0]  ld_i;
  logic        cnt_clr_i;
  logic [5:0]  cmp_fw_o;
  logic [5:0]  alu_fw_o;
  logic        stall_o;
  logic        bubble_o;
  logic [15:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  fwd_hazard_unit #(
    .NSRC(2), .NSTG(2), .RW(5), .CW(3), .LOAD_LAT(3)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .rs_i(rs_i), .rs_use_i(rs_use_i), .wr_rn_i(wr_rn_i), .we_i(we_i), .ld_i(ld_i),
    .cnt_clr_i(cnt_clr_i), .cmp_fw_o(cmp_fw_o), .alu_fw_o(alu_fw_o),
    .stall_o(stall_o), .bubble_o(bubble_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Load in stage 0 writing r7, decode reads r7 on operand 0.
  task automatic load_use(input logic ld);
    rs_i     = {5'd0, 5'd7};
    rs_use_i = 2'b01;
    wr_rn_i  = {5'd0, 5'd7};
    we_i     = 2'b01;
    ld_i     = {1'b0, ld};
  endtask

  initial begin
    rst = 1'b0; pause = 1'b0; flush = 1'b0; cnt_clr_i = 1'b0;
    rs_i = '0; rs_use_i = '0; wr_rn_i = '0; we_i = '0; ld_i = '0;

    // Reset state
    #3;
    chk("rst_alu_fw", alu_fw_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_bubble", bubble_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    tick();
    rst = 1'b1;
    tick();

    // 1: basic forward from stage 0 on operand 1
    rs_i = {5'd5, 5'd3}; rs_use_i = 2'b11; wr_rn_i = {5'd0, 5'd5}; we_i = 2'b01; ld_i = 2'b00;
    settle();
    chk("t1_cmp_op1", cmp_fw_o[5:3], 1);
    chk("t1_cmp_op0", cmp_fw_o[2:0], 0);
    chk("t1_alu_before_edge", alu_fw_o, 0);
    chk("t1_no_stall", stall_o, 0);
    tick();
    chk("t1_alu_op1", alu_fw_o[5:3], 1);
    chk("t1_alu_op0", alu_fw_o[2:0], 0);

    // 2: priority, stage 1 only, register 0, unused operand
    wr_rn_i = {5'd5, 5'd5}; we_i = 2'b11;
    settle();
    chk("t2_both_match_youngest", cmp_fw_o[5:3], 1);
    we_i = 2'b10;
    settle();
    chk("t2_stage1_only", cmp_fw_o[5:3], 2);
    rs_i = {5'd5, 5'd0}; wr_rn_i = {5'd5, 5'd0}; we_i = 2'b01;
    settle();
    chk("t2_reg0_no_fwd", cmp_fw_o, 0);
    rs_i = {5'd5, 5'd3}; wr_rn_i = {5'd0, 5'd5}; we_i = 2'b01; rs_use_i = 2'b01;
    tick();
    chk("t2_unused_alu_zero", alu_fw_o, 0);
    chk("t2_cmp_ungated", cmp_fw_o[5:3], 1);

    // 3: load-use stall of exactly three cycles
    load_use(1'b1);
    settle();
    chk("t3_c1_stall", stall_o, 1);
    chk("t3_c1_bubble", bubble_o, 1);
    tick();
    ld_i = 2'b00;
    settle();
    chk("t3_c2_stall", stall_o, 1);
    chk("t3_c2_bubble", bubble_o, 1);
    chk("t3_c2_alu_bubbled", alu_fw_o, 0);
    tick();
    chk("t3_c3_stall", stall_o, 1);
    chk("t3_c3_bubble", bubble_o, 1);
    tick();
    chk("t3_done_stall", stall_o, 0);
    chk("t3_done_bubble", bubble_o, 0);
    chk("t3_cnt", stall_cnt_o, 3);

    // 4: pause two cycles mid-HOLD stretches the stall but not the count
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("t4_cleared", stall_cnt_o, 0);
    load_use(1'b1);
    settle();
    chk("t4_c1_stall", stall_o, 1);
    tick();
    ld_i = 2'b00;
    settle();
    chk("t4_c2_stall", stall_o, 1);
    tick();
    pause = 1'b1;
    settle();
    chk("t4_c3_stall", stall_o, 1);
    chk("t4_c3_bubble", bubble_o, 0);
    tick();
    chk("t4_c4_stall", stall_o, 1);
    tick();
    pause = 1'b0;
    settle();
    chk("t4_c5_stall", stall_o, 1);
    chk("t4_c5_bubble", bubble_o, 1);
    tick();
    chk("t4_c6_stall", stall_o, 0);
    chk("t4_cnt", stall_cnt_o, 3);

    // 5a: flush in first HOLD cycle
    load_use(1'b1);
    tick();
    ld_i = 2'b00; flush = 1'b1;
    settle();
    chk("t5_hold_stall", stall_o, 1);
    tick();
    flush = 1'b0;
    settle();
    chk("t5_flush_stall", stall_o, 0);
    chk("t5_flush_alu", alu_fw_o, 0);

    // 5b: flush together with the hazard: no HOLD entry
    load_use(1'b1); flush = 1'b1;
    settle();
    chk("t5_flush_haz_comb", stall_o, 1);
    tick();
    flush = 1'b0; ld_i = 2'b00;
    settle();
    chk("t5_flush_haz_no_hold", stall_o, 0);

    // 5c: asynchronous reset mid-HOLD
    tick();
    load_use(1'b1);
    tick();
    ld_i = 2'b00;
    settle();
    chk("t5_pre_rst_stall", stall_o, 1);
    rst = 1'b0;
    settle();
    chk("t5_rst_stall", stall_o, 0);
    chk("t5_rst_bubble", bubble_o, 0);
    chk("t5_rst_alu", alu_fw_o, 0);
    chk("t5_rst_cnt", stall_cnt_o, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_after_rst_stall", stall_o, 0);

    // 6: saturation and clear-over-increment
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    load_use(1'b1);
    for (int i = 0; i < 65535; i++) tick();
    chk("t6_cnt_65535", stall_cnt_o, 16'hFFFF);
    tick();
    chk("t6_cnt_saturated", stall_cnt_o, 16'hFFFF);
    cnt_clr_i = 1'b1;
    settle();
    chk("t6_still_stalling", stall_o, 1);
    tick();
    chk("t6_clr_wins", stall_cnt_o, 0);
    cnt_clr_i = 1'b0;
    ld_i = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
